ts_packet_chk: RTL

- Receive-side checker for the MPEG-TS byte stream produced by ts_packet_gen: ts_data/ts_valid/ts_start/ts_end, one byte per accepted beat.
- Frames 188-byte packets, validates the 0x47 sync byte and the packet length, extracts header fields, and checks continuity-counter sequence for one selected PID.
- Keeps packet and error statistics.
- Sits on the loopback/receive path in Top_MedOIP, in the same clock domain as the generator.

---
 rtl/ts_packet_chk.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ts_packet_chk.sv
// Receive-side MPEG-TS checker: frames packets, validates sync/length, extracts header
// fields, checks continuity for one PID. Optional inter-packet gap monitor: TS_CHK_GAP_EN.
module ts_packet_chk #(
    parameter int          PKT_LEN   = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [12:0] pid_sel,
    input  logic [7:0]  ts_data,
    input  logic        ts_valid,
    input  logic        ts_start,
    input  logic        ts_end,
`ifdef TS_CHK_GAP_EN
    input  logic [15:0] gap_min,
    output logic [15:0] gap_last,
    output logic [15:0] gap_err_cnt,
`endif
    output logic        pkt_done,
    output logic [3:0]  pkt_err,
    output logic [12:0] pid,
    output logic [3:0]  cc,
    output logic        pusi,
    output logic [31:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

    localparam logic [8:0] LAST_IDX = 9'(PKT_LEN - 1);
    localparam logic [8:0] LEN_IDX  = 9'(PKT_LEN);

    state_t      state_r;
    logic [7:0]  idx_r;
    logic        sync_r, long_r;
    logic [12:0] pid_w_r;
    logic        pusi_w_r;
    logic [1:0]  afc_r;
    logic [3:0]  cc_w_r;
    logic        cc_init_r;
    logic [3:0]  cc_prev_r;

    logic        in_pkt_s, stray_s, term_start_s, term_end_s, one_byte_s, done_s;
    logic [8:0]  bidx_s;
    logic [12:0] hpid_s, fin_pid_s;
    logic        hpusi_s, fin_pusi_s;
    logic [1:0]  hafc_s, fin_afc_s;
    logic [3:0]  hcc_s, fin_cc_s;
    logic        fin_sync_s, fin_short_s, fin_long_s, chk_s, cc_bad_s, err_inc_s;

    assign in_pkt_s     = (state_r != IDLE);
    assign bidx_s       = {1'b0, idx_r} + 9'd1;
    assign stray_s      = ts_valid && !in_pkt_s && !ts_start;
    assign term_start_s = ts_valid && in_pkt_s && ts_start;
    assign term_end_s   = ts_valid && in_pkt_s && ts_end && !ts_start;
    assign one_byte_s   = ts_valid && !in_pkt_s && ts_start && ts_end;
    assign done_s       = term_start_s || term_end_s || one_byte_s;

    // Header fields including the byte on the current beat
    always_comb begin
        hpid_s  = pid_w_r;
        hpusi_s = pusi_w_r;
        hafc_s  = afc_r;
        hcc_s   = cc_w_r;
        if (ts_valid && (state_r == HDR)) begin
            case (idx_r)
                8'd0: begin
                    hpusi_s        = ts_data[6];
                    hpid_s[12:8]   = ts_data[4:0];
                end
                8'd1:    hpid_s[7:0] = ts_data;
                8'd2: begin
                    hafc_s = ts_data[5:4];
                    hcc_s  = ts_data[3:0];
                end
                default: hpid_s = pid_w_r;
            endcase
        end else begin
            hpid_s = pid_w_r;
        end
    end

    // Result of the packet terminating on this beat; a restarting beat belongs to the next packet
    always_comb begin
        fin_sync_s  = sync_r;
        fin_short_s = 1'b0;
        fin_long_s  = long_r;
        fin_pid_s   = hpid_s;
        fin_pusi_s  = hpusi_s;
        fin_afc_s   = hafc_s;
        fin_cc_s    = hcc_s;
        if (one_byte_s) begin
            fin_sync_s  = (ts_data != SYNC_BYTE);
            fin_short_s = 1'b1;
            fin_long_s  = 1'b0;
            fin_pid_s   = 13'd0;
            fin_pusi_s  = 1'b0;
            fin_afc_s   = 2'd0;
            fin_cc_s    = 4'd0;
        end else if (term_start_s) begin
            fin_short_s = !long_r;
            fin_pid_s   = pid_w_r;
            fin_pusi_s  = pusi_w_r;
            fin_afc_s   = afc_r;
            fin_cc_s    = cc_w_r;
        end else if (term_end_s) begin
            fin_short_s = (bidx_s < LAST_IDX);
            fin_long_s  = long_r || (bidx_s > LAST_IDX);
        end else begin
            fin_short_s = 1'b0;
        end
    end

    assign chk_s     = done_s && (fin_pid_s == pid_sel) && !fin_sync_s && !fin_short_s;
    assign cc_bad_s  = chk_s && cc_init_r &&
                       (fin_afc_s[0] ? (fin_cc_s != (cc_prev_r + 4'd1)) : (fin_cc_s != cc_prev_r));
    assign err_inc_s = (pkt_done && (pkt_err != 4'd0)) || stray_s;

    // Framing FSM, header capture, continuity state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 8'd0;
            sync_r    <= 1'b0;
            long_r    <= 1'b0;
            pid_w_r   <= 13'd0;
            pusi_w_r  <= 1'b0;
            afc_r     <= 2'd0;
            cc_w_r    <= 4'd0;
            cc_init_r <= 1'b0;
            cc_prev_r <= 4'd0;
            pkt_done  <= 1'b0;
            pkt_err   <= 4'd0;
            pid       <= 13'd0;
            cc        <= 4'd0;
            pusi      <= 1'b0;
            pkt_cnt   <= 32'd0;
            err_cnt   <= 16'd0;
        end else begin
            if (ts_valid && ts_start) begin
                state_r  <= (one_byte_s) ? IDLE : HDR;
                idx_r    <= 8'd0;
                sync_r   <= (ts_data != SYNC_BYTE);
                long_r   <= 1'b0;
                pid_w_r  <= 13'd0;
                pusi_w_r <= 1'b0;
                afc_r    <= 2'd0;
                cc_w_r   <= 4'd0;
            end else if (ts_valid && in_pkt_s && ts_end) begin
                state_r <= IDLE;
            end else if (ts_valid && in_pkt_s) begin
                pid_w_r  <= hpid_s;
                pusi_w_r <= hpusi_s;
                afc_r    <= hafc_s;
                cc_w_r   <= hcc_s;
                // Index freezes once the packet overruns; the long flag remembers it
                if (bidx_s >= LEN_IDX) begin
                    long_r <= 1'b1;
                end else begin
                    idx_r <= bidx_s[7:0];
                end
                if ((state_r == HDR) && (bidx_s == 9'd3)) begin
                    state_r <= PAY;
                end else begin
                    state_r <= state_r;
                end
            end else begin
                state_r <= state_r;
            end

            pkt_done <= done_s;
            pkt_err  <= done_s ? {cc_bad_s, fin_long_s, fin_short_s, fin_sync_s} : 4'd0;
            if (done_s) begin
                pid  <= fin_pid_s;
                cc   <= fin_cc_s;
                pusi <= fin_pusi_s;
            end else begin
                pid  <= pid;
            end

            if (clr) begin
                cc_init_r <= 1'b0;
            end else if (chk_s) begin
                cc_init_r <= 1'b1;
                cc_prev_r <= fin_cc_s;
            end else begin
                cc_init_r <= cc_init_r;
            end

            if (clr) begin
                pkt_cnt <= 32'd0;
                err_cnt <= 16'd0;
            end else begin
                pkt_cnt <= pkt_done ? pkt_cnt + 32'd1 : pkt_cnt;
                if (err_inc_s && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end else begin
                    err_cnt <= err_cnt;
                end
            end
        end
    end

`ifdef TS_CHK_GAP_EN
    logic        gap_run_r;
    logic [15:0] gap_cnt_r;

    // Idle-cycle counter between a packet end and the next packet start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_run_r   <= 1'b0;
            gap_cnt_r   <= 16'd0;
            gap_last    <= 16'd0;
            gap_err_cnt <= 16'd0;
        end else begin
            if (ts_valid && ts_end) begin
                gap_run_r <= 1'b1;
                gap_cnt_r <= 16'd0;
            end else if (ts_valid && ts_start) begin
                gap_run_r <= 1'b0;
            end else if (gap_run_r && (gap_cnt_r != 16'hFFFF)) begin
                gap_cnt_r <= gap_cnt_r + 16'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end

            if (ts_valid && ts_start && gap_run_r) begin
                gap_last <= gap_cnt_r;
            end else begin
                gap_last <= gap_last;
            end

            if (clr) begin
                gap_err_cnt <= 16'd0;
            end else if (ts_valid && ts_start && gap_run_r && (gap_cnt_r < gap_min) &&
                         (gap_err_cnt != 16'hFFFF)) begin
                gap_err_cnt <= gap_err_cnt + 16'd1;
            end else begin
                gap_err_cnt <= gap_err_cnt;
            end
        end
    end
`endif

endmodule
